// File: rtl/adrv9001_pkg.sv
// Shared types and constants for the ADRV9001 enable sequencers.
package adrv9001_pkg;

  localparam int ADRV9001_EN_CNT_W = 16;

  // Sequencer states; encodings 5..7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    EN_IDLE   = 3'd0,
    EN_SETUP  = 3'd1,
    EN_ACTIVE = 3'd2,
    EN_HOLD   = 3'd3,
    EN_GUARD  = 3'd4
  } adrv9001_en_state_t;

endpackage

// File: rtl/adrv9001_dwell_counter.sv
// Load/decrement dwell counter. A load of 0 is treated as 1, and the count
// parks at 1 so it never wraps; done is high once the last dwell cycle is reached.
module adrv9001_dwell_counter
  import adrv9001_pkg::*;
#(
  parameter int CNT_W = ADRV9001_EN_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             done
);

  logic [CNT_W-1:0] count_reg;

  // Load on state entry, otherwise count down towards 1 and stop there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= (load_value == '0) ? CNT_W'(1) : load_value;
    end else if (count_reg > CNT_W'(1)) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign done = (count_reg <= CNT_W'(1));

endmodule

// File: rtl/adrv9001_enable_sequencer.sv
// Per-channel enable sequencer: pin enable, setup dwell, data window,
// hold dwell, then a guard time before the pin may be raised again.
module adrv9001_enable_sequencer
  import adrv9001_pkg::*;
#(
  parameter int CNT_W = ADRV9001_EN_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_req,
  input  logic [CNT_W-1:0] setup_cycles,
  input  logic [CNT_W-1:0] hold_cycles,
  input  logic [CNT_W-1:0] guard_cycles,
  output logic             enable,
  output logic             data_en,
  output logic             busy,
  output logic [2:0]       state,
  output logic             active_pulse,
  output logic             abort_pulse
);

  adrv9001_en_state_t state_reg, state_next;
  logic               load;
  logic [CNT_W-1:0]   load_value;
  logic               dwell_done;
  logic               active_next, abort_next;
  logic               enable_reg, data_en_reg, busy_reg;
  logic               active_pulse_reg, abort_pulse_reg;

  adrv9001_dwell_counter #(
    .CNT_W(CNT_W)
  ) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_value (load_value),
    .done       (dwell_done)
  );

  // Next-state decision; the dwell counter is loaded on entry to every timed state.
  always_comb begin
    state_next  = state_reg;
    load        = 1'b0;
    load_value  = '0;
    active_next = 1'b0;
    abort_next  = 1'b0;
    case (state_reg)
      EN_IDLE: begin
        if (en_req) begin
          state_next = EN_SETUP;
          load       = 1'b1;
          load_value = setup_cycles;
        end
      end
      EN_SETUP: begin
        // A withdrawn request beats an expiring dwell; no data passed, so skip HOLD.
        if (!en_req) begin
          state_next = EN_GUARD;
          load       = 1'b1;
          load_value = guard_cycles;
          abort_next = 1'b1;
        end else if (dwell_done) begin
          state_next  = EN_ACTIVE;
          active_next = 1'b1;
        end
      end
      EN_ACTIVE: begin
        if (!en_req) begin
          state_next = EN_HOLD;
          load       = 1'b1;
          load_value = hold_cycles;
        end
      end
      EN_HOLD: begin
        if (dwell_done) begin
          state_next = EN_GUARD;
          load       = 1'b1;
          load_value = guard_cycles;
        end
      end
      EN_GUARD: begin
        if (dwell_done) begin
          state_next = EN_IDLE;
        end
      end
      default: state_next = EN_IDLE;
    endcase
  end

  // State and outputs are registered together so they always agree with each other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= EN_IDLE;
      enable_reg       <= 1'b0;
      data_en_reg      <= 1'b0;
      busy_reg         <= 1'b0;
      active_pulse_reg <= 1'b0;
      abort_pulse_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      enable_reg       <= (state_next == EN_SETUP) || (state_next == EN_ACTIVE) ||
                          (state_next == EN_HOLD);
      data_en_reg      <= (state_next == EN_ACTIVE);
      busy_reg         <= (state_next != EN_IDLE);
      active_pulse_reg <= active_next;
      abort_pulse_reg  <= abort_next;
    end
  end

  assign enable       = enable_reg;
  assign data_en      = data_en_reg;
  assign busy         = busy_reg;
  assign state        = state_reg;
  assign active_pulse = active_pulse_reg;
  assign abort_pulse  = abort_pulse_reg;

endmodule
